axi_mem: RTL and testbench



---
 rtl/utils_pkg.sv | 67 ++++++
 rtl/sp_ram.sv | 24 ++
 rtl/axi_mem.sv | 161 ++++++++++++++++
 tb/tb_axi_mem.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/utils_pkg.sv
// Shared AXI4 types for SoC-level slaves: channel structs, burst/resp encodings
// and the memory-slave FSM state set.
package utils_pkg;

   localparam int unsigned AXI_ID_W = 4;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'b00,
      BURST_INCR  = 2'b01,
      BURST_WRAP  = 2'b10
   } axi_burst_t;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } axi_resp_t;

   typedef enum logic [1:0] {
      IDLE,
      RD,
      WR,
      WRESP
   } axi_mem_state_t;

   typedef struct packed {
      logic [AXI_ID_W-1:0] awid;
      logic [31:0]         awaddr;
      logic [7:0]          awlen;
      logic [2:0]          awsize;
      logic [1:0]          awburst;
      logic                awvalid;
      logic [31:0]         wdata;
      logic [3:0]          wstrb;
      logic                wlast;
      logic                wvalid;
      logic                bready;
      logic [AXI_ID_W-1:0] arid;
      logic [31:0]         araddr;
      logic [7:0]          arlen;
      logic [2:0]          arsize;
      logic [1:0]          arburst;
      logic                arvalid;
      logic                rready;
   } s_axi_mosi_t;

   typedef struct packed {
      logic                awready;
      logic                wready;
      logic [AXI_ID_W-1:0] bid;
      logic [1:0]          bresp;
      logic                bvalid;
      logic                arready;
      logic [AXI_ID_W-1:0] rid;
      logic [31:0]         rdata;
      logic [1:0]          rresp;
      logic                rlast;
      logic                rvalid;
   } s_axi_miso_t;

   // Address increment applied after each beat; FIXED bursts stay put.
   function automatic logic [31:0] beat_step(input logic [2:0] size, input logic [1:0] burst);
      return (burst == BURST_INCR) ? (32'd1 << size) : '0;
   endfunction

endpackage

// File: rtl/sp_ram.sv
// Word-organised single-port RAM with byte-lane write enables and a
// registered synchronous read port.
module sp_ram #(
  parameter int unsigned DEPTH     = 4096,
  parameter string       INIT_FILE = "",
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    we,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < 4; b++) begin
      if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/axi_mem.sv
// AXI4 memory slave: one transaction at a time, round-robin between reads and
// writes, SLVERR for unsupported bursts/sizes and out-of-range beats.
module axi_mem
   import utils_pkg::*;
#(
   parameter int unsigned MEM_KB    = 16,
   parameter string       INIT_FILE = ""
) (
   input  logic        clk,
   input  logic        rst,
   input  s_axi_mosi_t axi_mosi_i,
   output s_axi_miso_t axi_miso_o
);

   localparam int unsigned DEPTH     = MEM_KB * 256;
   localparam int unsigned AW        = $clog2(DEPTH);
   localparam logic [31:0] MEM_BYTES = 32'(MEM_KB * 1024);

   axi_mem_state_t state_q, state_d;
   logic                pref_rd_q;
   logic [31:0]         addr_q;
   logic [7:0]          len_q;
   logic [2:0]          size_q;
   logic [1:0]          burst_q;
   logic [AXI_ID_W-1:0] id_q;
   logic                err_q;
   logic [7:0]          cnt_q;
   logic                rvalid_q;

   logic          ar_hs, aw_hs, w_hs, r_hs;
   logic          beat_oob, beat_last;
   logic [31:0]   next_addr;
   logic [AW-1:0] ram_addr;
   logic [3:0]    ram_we;
   logic [31:0]   ram_rdata;

   function automatic logic bad_req(input logic [1:0] burst, input logic [2:0] size,
                                    input logic [31:0] addr);
      return !(burst == BURST_FIXED || burst == BURST_INCR) || (size > 3'd2) ||
             (addr >= MEM_BYTES);
   endfunction

   assign ar_hs     = (state_q == IDLE) && axi_mosi_i.arvalid && (!axi_mosi_i.awvalid || pref_rd_q);
   assign aw_hs     = (state_q == IDLE) && axi_mosi_i.awvalid && (!axi_mosi_i.arvalid || !pref_rd_q);
   assign w_hs      = (state_q == WR) && axi_mosi_i.wvalid;
   assign r_hs      = rvalid_q && axi_mosi_i.rready;
   assign beat_oob  = addr_q >= MEM_BYTES;
   assign beat_last = cnt_q == len_q;
   assign next_addr = addr_q + beat_step(size_q, burst_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (ar_hs) state_d = RD;
                  else if (aw_hs) state_d = WR;
         RD:      if (r_hs && beat_last) state_d = IDLE;
         WR:      if (w_hs && axi_mosi_i.wlast) state_d = WRESP;
         WRESP:   if (axi_mosi_i.bready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pref_rd_q <= 1'b1;
         addr_q    <= '0;
         len_q     <= '0;
         size_q    <= '0;
         burst_q   <= '0;
         id_q      <= '0;
         err_q     <= 1'b0;
         cnt_q     <= '0;
         rvalid_q  <= 1'b0;
      end else begin
         if (ar_hs) begin
            addr_q    <= axi_mosi_i.araddr;
            len_q     <= axi_mosi_i.arlen;
            size_q    <= axi_mosi_i.arsize;
            burst_q   <= axi_mosi_i.arburst;
            id_q      <= axi_mosi_i.arid;
            err_q     <= bad_req(axi_mosi_i.arburst, axi_mosi_i.arsize, axi_mosi_i.araddr);
            cnt_q     <= '0;
            rvalid_q  <= 1'b1;
            pref_rd_q <= 1'b0;
         end else if (aw_hs) begin
            addr_q    <= axi_mosi_i.awaddr;
            len_q     <= axi_mosi_i.awlen;
            size_q    <= axi_mosi_i.awsize;
            burst_q   <= axi_mosi_i.awburst;
            id_q      <= axi_mosi_i.awid;
            err_q     <= bad_req(axi_mosi_i.awburst, axi_mosi_i.awsize, axi_mosi_i.awaddr);
            cnt_q     <= '0;
            pref_rd_q <= 1'b1;
         end
         if (state_q == RD && r_hs) begin
            if (beat_last) begin
               rvalid_q <= 1'b0;
            end else begin
               addr_q <= next_addr;
               cnt_q  <= cnt_q + 8'd1;
            end
         end
         // Write errors are sticky so that bresp reports any bad beat in the burst.
         if (w_hs) begin
            if (beat_oob || (axi_mosi_i.wlast && !beat_last)) err_q <= 1'b1;
            if (!axi_mosi_i.wlast) begin
               addr_q <= next_addr;
               cnt_q  <= cnt_q + 8'd1;
            end
         end
      end
   end

   // Hold the RAM on the presented beat while R is stalled so rdata stays put.
   always_comb begin
      ram_addr = addr_q[AW+1:2];
      unique case (state_q)
         IDLE:    ram_addr = axi_mosi_i.araddr[AW+1:2];
         RD:      if (r_hs && !beat_last) ram_addr = next_addr[AW+1:2];
         default: ram_addr = addr_q[AW+1:2];
      endcase
   end

   assign ram_we = (w_hs && !err_q && !beat_oob) ? axi_mosi_i.wstrb : '0;

   sp_ram #(
      .DEPTH     (DEPTH),
      .INIT_FILE (INIT_FILE)
   ) u_ram (
      .clk   (clk),
      .addr  (ram_addr),
      .we    (ram_we),
      .wdata (axi_mosi_i.wdata),
      .rdata (ram_rdata)
   );

   always_comb begin
      axi_miso_o         = '0;
      axi_miso_o.arready = ar_hs;
      axi_miso_o.awready = aw_hs;
      axi_miso_o.wready  = state_q == WR;
      axi_miso_o.bvalid  = state_q == WRESP;
      if (state_q == WRESP) begin
         axi_miso_o.bid   = id_q;
         axi_miso_o.bresp = err_q ? RESP_SLVERR : RESP_OKAY;
      end
      axi_miso_o.rvalid = rvalid_q;
      if (rvalid_q) begin
         axi_miso_o.rid   = id_q;
         axi_miso_o.rlast = beat_last;
         axi_miso_o.rresp = (err_q || beat_oob) ? RESP_SLVERR : RESP_OKAY;
         axi_miso_o.rdata = (err_q || beat_oob) ? '0 : ram_rdata;
      end
   end

endmodule

// File: tb/tb_axi_mem.sv
// Directed bench for axi_mem: stimulus pushes expected R/B responses into
// queues, a negedge monitor pops and compares them on each handshake.
module tb_axi_mem
   import utils_pkg::*;
;

   logic        clk = 1'b0;
   logic        rst;
   s_axi_mosi_t mosi;
   s_axi_miso_t miso;

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
      logic [3:0]  id;
   } rexp_t;

   typedef struct packed {
      logic [1:0] resp;
      logic [3:0] id;
   } bexp_t;

   rexp_t rq[$];
   bexp_t bq[$];
   int    checks = 0;
   int    errors = 0;

   logic [31:0] hold_data;
   logic [2:0]  hold_ctl;
   bit          stalled = 0;

   axi_mem #(
      .MEM_KB    (16),
      .INIT_FILE ("")
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .axi_mosi_i (mosi),
      .axi_miso_o (miso)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   task automatic tmo(input string name);
      checks++;
      errors++;
      $display("FAIL %s: no response within cycle budget", name);
   endtask

   always @(negedge clk) begin
      if (rst) begin
         stalled = 0;
      end else begin
         if (miso.rvalid) begin
            if (stalled) begin
               chk("r_stall_data", miso.rdata, hold_data);
               chk("r_stall_ctl", 32'({miso.rresp, miso.rlast}), 32'(hold_ctl));
            end
            if (mosi.rready) begin
               stalled = 0;
               if (rq.size() == 0) tmo("r_unexpected_beat");
               else begin
                  rexp_t e;
                  e = rq.pop_front();
                  chk("r_data", miso.rdata, e.data);
                  chk("r_resp", 32'(miso.rresp), 32'(e.resp));
                  chk("r_last", 32'(miso.rlast), 32'(e.last));
                  chk("r_id", 32'(miso.rid), 32'(e.id));
               end
            end else begin
               stalled   = 1;
               hold_data = miso.rdata;
               hold_ctl  = {miso.rresp, miso.rlast};
            end
         end
         if (miso.bvalid && mosi.bready) begin
            if (bq.size() == 0) tmo("b_unexpected");
            else begin
               bexp_t e;
               e = bq.pop_front();
               chk("b_resp", 32'(miso.bresp), 32'(e.resp));
               chk("b_id", 32'(miso.bid), 32'(e.id));
            end
         end
      end
   end

   function automatic rexp_t rx(input logic [31:0] d, input logic [1:0] r, input logic l,
                                input logic [3:0] id);
      rexp_t e;
      e.data = d; e.resp = r; e.last = l; e.id = id;
      return e;
   endfunction

   function automatic bexp_t bx(input logic [1:0] r, input logic [3:0] id);
      bexp_t e;
      e.resp = r; e.id = id;
      return e;
   endfunction

   task automatic send_aw(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                          input logic [1:0] burst);
      bit ok = 0;
      mosi.awid = id; mosi.awaddr = a; mosi.awlen = len;
      mosi.awsize = 3'd2; mosi.awburst = burst; mosi.awvalid = 1'b1;
      for (int c = 0; c < 100 && !ok; c++) begin
         @(negedge clk); ok = miso.awready;
         @(posedge clk); #1;
      end
      mosi.awvalid = 1'b0;
      if (!ok) tmo("aw_handshake");
   endtask

   task automatic send_ar(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                          input logic [1:0] burst);
      bit ok = 0;
      mosi.arid = id; mosi.araddr = a; mosi.arlen = len;
      mosi.arsize = 3'd2; mosi.arburst = burst; mosi.arvalid = 1'b1;
      for (int c = 0; c < 100 && !ok; c++) begin
         @(negedge clk); ok = miso.arready;
         @(posedge clk); #1;
      end
      mosi.arvalid = 1'b0;
      if (!ok) tmo("ar_handshake");
   endtask

   task automatic w_beat(input logic [31:0] d, input logic [3:0] strb, input logic last);
      bit ok = 0;
      mosi.wdata = d; mosi.wstrb = strb; mosi.wlast = last; mosi.wvalid = 1'b1;
      for (int c = 0; c < 100 && !ok; c++) begin
         @(negedge clk); ok = miso.wready;
         @(posedge clk); #1;
      end
      mosi.wvalid = 1'b0;
      if (!ok) tmo("w_handshake");
   endtask

   task automatic wait_done();
      for (int c = 0; c < 2000 && (rq.size() != 0 || bq.size() != 0); c++) @(posedge clk);
      if (rq.size() != 0 || bq.size() != 0) tmo("drain_responses");
      rq.delete();
      bq.delete();
      @(posedge clk); #1;
   endtask

   task automatic wr1(input logic [31:0] a, input logic [31:0] d, input logic [3:0] strb,
                      input logic [1:0] resp);
      bq.push_back(bx(resp, 4'd1));
      send_aw(4'd1, a, 8'd0, BURST_INCR);
      w_beat(d, strb, 1'b1);
      wait_done();
   endtask

   task automatic rd1(input logic [31:0] a, input logic [31:0] d);
      rq.push_back(rx(d, RESP_OKAY, 1'b1, 4'd2));
      send_ar(4'd2, a, 8'd0, BURST_INCR);
      wait_done();
   endtask

   // Simultaneous AR and AW (with its W beat queued); records grant order.
   task automatic both(input logic [31:0] ra, input logic [3:0] rid, input logic [31:0] wa,
                       input logic [3:0] wid, input logic [31:0] wd, input string tag);
      int g0 = 0, g1 = 0, n = 0;
      bit a, w, d;
      mosi.arid = rid; mosi.araddr = ra; mosi.arlen = 8'd0; mosi.arsize = 3'd2;
      mosi.arburst = BURST_INCR; mosi.arvalid = 1'b1;
      mosi.awid = wid; mosi.awaddr = wa; mosi.awlen = 8'd0; mosi.awsize = 3'd2;
      mosi.awburst = BURST_INCR; mosi.awvalid = 1'b1;
      mosi.wdata = wd; mosi.wstrb = 4'hF; mosi.wlast = 1'b1; mosi.wvalid = 1'b1;
      for (int c = 0; c < 200 && (mosi.arvalid || mosi.awvalid || mosi.wvalid); c++) begin
         @(negedge clk);
         a = miso.arready && mosi.arvalid;
         w = miso.awready && mosi.awvalid;
         d = miso.wready && mosi.wvalid;
         @(posedge clk); #1;
         if (a) begin mosi.arvalid = 1'b0; if (n == 0) g0 = 1; else g1 = 1; n++; end
         if (w) begin mosi.awvalid = 1'b0; if (n == 0) g0 = 2; else g1 = 2; n++; end
         if (d) mosi.wvalid = 1'b0;
      end
      if (mosi.arvalid || mosi.awvalid || mosi.wvalid) tmo({tag, "_grant"});
      mosi.arvalid = 1'b0; mosi.awvalid = 1'b0; mosi.wvalid = 1'b0;
      chk({tag, "_first_is_read"}, g0, 1);
      chk({tag, "_second_is_write"}, g1, 2);
      wait_done();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int run;
      mosi = '0;
      mosi.bready = 1'b1;
      mosi.rready = 1'b1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", 32'({miso.awready, miso.wready, miso.arready}), 0);
      chk("rst_b", 32'({miso.bvalid, miso.bresp}), 0);
      chk("rst_r", 32'({miso.rvalid, miso.rresp, miso.rlast}), 0);
      chk("rst_rdata", miso.rdata, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Single write then read; B two cycles after AW, R one cycle after AR.
      bq.push_back(bx(RESP_OKAY, 4'd1));
      send_aw(4'd1, 32'h10, 8'd0, BURST_INCR);
      w_beat(32'hDEADBEEF, 4'hF, 1'b1);
      chk("b_latency", 32'(miso.bvalid), 1);
      wait_done();
      rq.push_back(rx(32'hDEADBEEF, RESP_OKAY, 1'b1, 4'd2));
      send_ar(4'd2, 32'h10, 8'd0, BURST_INCR);
      chk("r_latency", 32'(miso.rvalid), 1);
      wait_done();

      // Byte strobes and R backpressure.
      wr1(32'h20, 32'hFFFFFFFF, 4'hF, RESP_OKAY);
      bq.push_back(bx(RESP_OKAY, 4'd3));
      send_aw(4'd3, 32'h24, 8'd2, BURST_INCR);
      for (int i = 0; i < 3; i++) w_beat(32'h10000000 + 32'(i) * 32'h01010101, 4'hF, i == 2);
      wait_done();
      wr1(32'h20, 32'h11223344, 4'b0101, RESP_OKAY);
      rq.push_back(rx(32'hFF22FF44, RESP_OKAY, 1'b0, 4'd4));
      rq.push_back(rx(32'h10000000, RESP_OKAY, 1'b0, 4'd4));
      rq.push_back(rx(32'h11010101, RESP_OKAY, 1'b0, 4'd4));
      rq.push_back(rx(32'h12020202, RESP_OKAY, 1'b1, 4'd4));
      send_ar(4'd4, 32'h20, 8'd3, BURST_INCR);
      for (int k = 0; k < 40 && rq.size() != 0; k++) begin
         mosi.rready = (k % 4 == 0) || (k % 4 == 3);
         @(posedge clk); #1;
      end
      mosi.rready = 1'b1;
      wait_done();

      // Arbitration: a write first leaves reads preferred for both pairs.
      wr1(32'h30, 32'hCAFE0030, 4'hF, RESP_OKAY);
      rq.push_back(rx(32'hCAFE0030, RESP_OKAY, 1'b1, 4'd5));
      bq.push_back(bx(RESP_OKAY, 4'd6));
      both(32'h30, 4'd5, 32'h34, 4'd6, 32'h00001234, "arb1");
      rq.push_back(rx(32'h00001234, RESP_OKAY, 1'b1, 4'd7));
      bq.push_back(bx(RESP_OKAY, 4'd8));
      both(32'h34, 4'd7, 32'h38, 4'd8, 32'h00005678, "arb2");
      rd1(32'h38, 32'h00005678);

      // Error cases.
      rq.push_back(rx(32'h0, RESP_SLVERR, 1'b1, 4'd9));
      send_ar(4'd9, 32'h10, 8'd0, BURST_WRAP);
      wait_done();
      wr1(32'h0, 32'h00C0FFEE, 4'hF, RESP_OKAY);
      wr1(32'h4000, 32'hFFFFFFFF, 4'hF, RESP_SLVERR);
      rd1(32'h0, 32'h00C0FFEE);
      bq.push_back(bx(RESP_SLVERR, 4'd10));
      send_aw(4'd10, 32'h40, 8'd3, BURST_INCR);
      w_beat(32'hAAAA0000, 4'hF, 1'b0);
      w_beat(32'hAAAA0001, 4'hF, 1'b1);
      wait_done();
      rq.push_back(rx(32'hAAAA0000, RESP_OKAY, 1'b0, 4'd11));
      rq.push_back(rx(32'hAAAA0001, RESP_OKAY, 1'b1, 4'd11));
      send_ar(4'd11, 32'h40, 8'd1, BURST_INCR);
      wait_done();
      wr1(32'h3FFC, 32'h77777777, 4'hF, RESP_OKAY);
      rq.push_back(rx(32'h77777777, RESP_OKAY, 1'b0, 4'd12));
      rq.push_back(rx(32'h0, RESP_SLVERR, 1'b1, 4'd12));
      send_ar(4'd12, 32'h3FFC, 8'd1, BURST_INCR);
      wait_done();

      // Reset during beat 2 of an 8-beat read.
      bq.push_back(bx(RESP_OKAY, 4'd13));
      send_aw(4'd13, 32'h100, 8'd7, BURST_INCR);
      for (int i = 0; i < 8; i++) w_beat(32'hB0 + 32'(i), 4'hF, i == 7);
      wait_done();
      rq.push_back(rx(32'hB0, RESP_OKAY, 1'b0, 4'd14));
      rq.push_back(rx(32'hB1, RESP_OKAY, 1'b0, 4'd14));
      send_ar(4'd14, 32'h100, 8'd7, BURST_INCR);
      @(posedge clk);
      @(posedge clk); #1;
      chk("midrd_beat2_valid", 32'(miso.rvalid), 1);
      rst = 1'b1;
      #1;
      chk("midrd_rvalid_drop", 32'(miso.rvalid), 0);
      chk("midrd_rq_drained", rq.size(), 0);
      rq.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      rd1(32'h100, 32'hB0);
      rd1(32'h10C, 32'hB3);

      // 256-beat INCR write and read back at full throughput.
      bq.push_back(bx(RESP_OKAY, 4'd15));
      send_aw(4'd15, 32'h0, 8'd255, BURST_INCR);
      for (int i = 0; i < 256; i++) w_beat(32'hA5000000 + 32'(i), 4'hF, i == 255);
      wait_done();
      for (int i = 0; i < 256; i++)
         rq.push_back(rx(32'hA5000000 + 32'(i), RESP_OKAY, i == 255, 4'd6));
      send_ar(4'd6, 32'h0, 8'd255, BURST_INCR);
      run = 0;
      for (int i = 0; i < 256; i++) begin
         if (miso.rvalid) run++;
         @(posedge clk); #1;
      end
      chk("maxburst_rvalid_cycles", run, 256);
      chk("maxburst_done", 32'(miso.rvalid), 0);
      wait_done();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
